// File: rtl/hpdcache_sram_ecc_rmw.sv
// Write-path front end for the ECC 1RW SRAM. Sparse-byte-enable writes become a
// read / merge / full-word write sequence. Reads and full-word writes go straight through.
module hpdcache_sram_ecc_rmw #(
  parameter int ADDR_SIZE = 6,
  parameter int DATA_SIZE = 64,
  parameter int NDATA     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_we_i,
  input  logic [ADDR_SIZE-1:0]           req_addr_i,
  input  logic [NDATA*DATA_SIZE-1:0]     req_wdata_i,
  input  logic [NDATA*DATA_SIZE/8-1:0]   req_wbe_i,
  output logic                           rsp_valid_o,
  output logic [NDATA*DATA_SIZE-1:0]     rsp_rdata_o,
  output logic [NDATA-1:0]               rsp_err_cor_o,
  output logic [NDATA-1:0]               rsp_err_unc_o,
  output logic                           rmw_abort_o,
  input  logic                           cnt_clr_i,
  output logic [CNT_WIDTH-1:0]           cnt_cor_o,
  output logic [CNT_WIDTH-1:0]           cnt_unc_o,
  output logic                           sram_cs_o,
  output logic                           sram_we_o,
  output logic [ADDR_SIZE-1:0]           sram_addr_o,
  output logic [NDATA*DATA_SIZE-1:0]     sram_wdata_o,
  output logic [NDATA*DATA_SIZE/8-1:0]   sram_wbe_o,
  input  logic [NDATA*DATA_SIZE-1:0]     sram_rdata_i,
  input  logic [NDATA-1:0]               sram_err_cor_i,
  input  logic [NDATA-1:0]               sram_err_unc_i
);
  localparam int BYTES = DATA_SIZE / 8;
  localparam int W     = NDATA * DATA_SIZE;
  localparam int BE    = NDATA * BYTES;

  typedef enum logic [1:0] {IDLE, RD_WAIT, MERGE} state_e;
  state_e state, state_nxt;

  logic [ADDR_SIZE-1:0] addr_q;
  logic [W-1:0]         wdata_q, merged;
  logic [BE-1:0]        wbe_q, touch_be;
  logic [NDATA-1:0]     req_part, q_touch;
  logic                 unc_hit;

  for (genvar i = 0; i < NDATA; i++) begin : g_word
    assign req_part[i] = (|req_wbe_i[i*BYTES +: BYTES]) && !(&req_wbe_i[i*BYTES +: BYTES]);
    assign q_touch[i]  = |wbe_q[i*BYTES +: BYTES];
    assign touch_be[i*BYTES +: BYTES] = {BYTES{q_touch[i]}};
  end

  // SRAM read data is already ECC-corrected, so merging it is safe unless flagged unc
  for (genvar b = 0; b < BE; b++) begin : g_byte
    assign merged[b*8 +: 8] = wbe_q[b] ? wdata_q[b*8 +: 8] : sram_rdata_i[b*8 +: 8];
  end

  assign unc_hit = |(sram_err_unc_i & q_touch);

  // Outputs are gated with rst_n so a reset landing in MERGE never writes the SRAM
  always_comb begin
    state_nxt    = state;
    req_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    rmw_abort_o  = 1'b0;
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = req_addr_i;
    sram_wdata_o = req_wdata_i;
    sram_wbe_o   = '0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          req_ready_o = 1'b1;
          if (req_valid_i) begin
            sram_cs_o = 1'b1;
            if (!req_we_i) begin
              state_nxt = RD_WAIT;
            end else if (|req_part) begin
              state_nxt = MERGE;
            end else begin
              sram_we_o  = 1'b1;
              sram_wbe_o = req_wbe_i;
            end
          end
        end
        RD_WAIT: begin
          rsp_valid_o = 1'b1;
          state_nxt   = IDLE;
        end
        MERGE: begin
          sram_addr_o  = addr_q;
          sram_wdata_o = merged;
          state_nxt    = IDLE;
          if (unc_hit) begin
            rmw_abort_o = 1'b1;
          end else begin
            sram_cs_o  = 1'b1;
            sram_we_o  = 1'b1;
            sram_wbe_o = touch_be;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign rsp_rdata_o   = rsp_valid_o ? sram_rdata_i : '0;
  assign rsp_err_cor_o = rsp_valid_o ? sram_err_cor_i : '0;
  assign rsp_err_unc_o = rsp_valid_o ? sram_err_unc_i : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid_i && req_we_i) begin
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      wbe_q   <= req_wbe_i;
    end
  end

  logic [CNT_WIDTH:0] cor_sum, unc_sum;
  assign cor_sum = {1'b0, cnt_cor_o} + (CNT_WIDTH+1)'($countones(sram_err_cor_i));
  assign unc_sum = {1'b0, cnt_unc_o} + (CNT_WIDTH+1)'($countones(sram_err_unc_i));

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr_i) begin
      cnt_cor_o <= '0;
      cnt_unc_o <= '0;
    end else if (state != IDLE) begin
      cnt_cor_o <= cor_sum[CNT_WIDTH] ? '1 : cor_sum[CNT_WIDTH-1:0];
      cnt_unc_o <= unc_sum[CNT_WIDTH] ? '1 : unc_sum[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_hpdcache_sram_ecc_rmw.sv
// Directed bench for the ECC RMW write-path controller: reads, full/none/partial
// writes, abort on uncorrectable, counters with clear/saturation, reset mid-merge.
module tb_hpdcache_sram_ecc_rmw;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_we;
  logic [5:0]   req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wbe;
  logic         rsp_valid;
  logic [127:0] rsp_rdata;
  logic [1:0]   rsp_err_cor, rsp_err_unc;
  logic         rmw_abort, cnt_clr;
  logic [15:0]  cnt_cor, cnt_unc;
  logic         sram_cs, sram_we;
  logic [5:0]   sram_addr;
  logic [127:0] sram_wdata, sram_rdata;
  logic [15:0]  sram_wbe;
  logic [1:0]   sram_err_cor, sram_err_unc;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  hpdcache_sram_ecc_rmw dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wbe_i(req_wbe),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_err_cor_o(rsp_err_cor), .rsp_err_unc_o(rsp_err_unc),
    .rmw_abort_o(rmw_abort), .cnt_clr_i(cnt_clr),
    .cnt_cor_o(cnt_cor), .cnt_unc_o(cnt_unc),
    .sram_cs_o(sram_cs), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_wbe_o(sram_wbe),
    .sram_rdata_i(sram_rdata), .sram_err_cor_i(sram_err_cor), .sram_err_unc_i(sram_err_unc)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // advance one clock; inputs change just after the edge, checks happen mid-cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wbe = '0; cnt_clr = 1'b0;
    sram_rdata = '0; sram_err_cor = '0; sram_err_unc = '0;
    tick(); tick();
    settle();
    chk("rst_ready", req_ready, 0);
    chk("rst_cs", sram_cs, 0);
    chk("rst_cnt_cor", cnt_cor, 0);
    chk("rst_cnt_unc", cnt_unc, 0);
    rst_n = 1'b1;
    settle();
    chk("idle_ready", req_ready, 1);
    tick();

    // read addr 5
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd5;
    settle();
    chk("rd_cs", sram_cs, 1);
    chk("rd_we", sram_we, 0);
    chk("rd_addr", sram_addr, 5);
    tick();
    req_valid = 1'b0;
    sram_rdata = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    settle();
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_rdata, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    chk("rd_rsp_flags", {rsp_err_cor, rsp_err_unc}, 0);
    chk("rd_wait_ready", req_ready, 0);
    tick();
    settle();
    chk("rd_ready_again", req_ready, 1);
    chk("rd_rsp_done", rsp_valid, 0);
    tick();

    // full write addr 3
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd3;
    req_wdata = {2{64'hA5A5_A5A5_A5A5_A5A5}}; req_wbe = 16'hFFFF;
    settle();
    chk("fw_cs_we", {sram_cs, sram_we}, 2'b11);
    chk("fw_wbe", sram_wbe, 16'hFFFF);
    chk("fw_wdata", sram_wdata, {2{64'hA5A5_A5A5_A5A5_A5A5}});
    chk("fw_addr", sram_addr, 3);
    tick();
    // none write: still a write with wbe=0
    req_wbe = 16'h0000;
    settle();
    chk("nw_ready", req_ready, 1);
    chk("nw_cs_we", {sram_cs, sram_we}, 2'b11);
    chk("nw_wbe", sram_wbe, 0);
    tick();

    // partial write addr 7, word0 byte0 = EE
    req_addr = 6'd7; req_wbe = 16'h0001;
    req_wdata = {64'hDEAD_BEEF_DEAD_BEEF, 64'h0000_0000_0000_00EE};
    settle();
    chk("pw_rd_cs_we", {sram_cs, sram_we}, 2'b10);
    chk("pw_rd_addr", sram_addr, 7);
    tick();
    req_valid = 1'b0; req_addr = 6'd9; req_wdata = '0; req_wbe = '1;
    sram_rdata = {64'hCAFE_F00D_CAFE_F00D, 64'h0123_4567_89AB_CDEF};
    settle();
    chk("pw_wr_cs_we", {sram_cs, sram_we}, 2'b11);
    chk("pw_wr_addr", sram_addr, 7);
    chk("pw_wr_data", sram_wdata, {64'hCAFE_F00D_CAFE_F00D, 64'h0123_4567_89AB_CDEE});
    chk("pw_wr_wbe", sram_wbe, 16'h00FF);
    chk("pw_no_abort_rsp", {rmw_abort, rsp_valid, req_ready}, 0);
    tick();
    settle();
    chk("pw_idle", {req_ready, sram_cs}, 2'b10);

    // same partial write, uncorrectable on touched word0
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd7; req_wbe = 16'h0001;
    req_wdata = {64'h0, 64'hEE};
    tick();
    req_valid = 1'b0; sram_err_unc = 2'b01;
    settle();
    chk("unc_no_write", sram_cs, 0);
    chk("unc_abort", rmw_abort, 1);
    tick();
    sram_err_unc = 2'b00;
    settle();
    chk("unc_abort_pulse", rmw_abort, 0);
    chk("unc_cnt", cnt_unc, 1);

    // partial write on word1, correctable error on word1
    req_valid = 1'b1; req_wbe = 16'h0300; req_wdata = {64'h5A5A, 64'h0};
    tick();
    req_valid = 1'b0; sram_err_cor = 2'b10;
    sram_rdata = {64'h1122_3344_5566_7788, 64'hFFFF_FFFF_FFFF_FFFF};
    settle();
    chk("cor_wr_data", sram_wdata, {64'h1122_3344_5566_5A5A, 64'hFFFF_FFFF_FFFF_FFFF});
    chk("cor_wr_wbe", sram_wbe, 16'hFF00);
    chk("cor_wr_cs_we", {sram_cs, sram_we, rmw_abort}, 3'b110);
    tick();
    sram_err_cor = 2'b00;
    settle();
    chk("cor_cnt", cnt_cor, 1);
    // clear wins over a simultaneous event
    req_valid = 1'b1; req_we = 1'b0;
    tick();
    req_valid = 1'b0; sram_err_cor = 2'b01; cnt_clr = 1'b1;
    settle();
    chk("clr_rsp_cor", rsp_err_cor, 2'b01);
    tick();
    cnt_clr = 1'b0; sram_err_cor = 2'b00;
    settle();
    chk("clr_cnt_cor", cnt_cor, 0);
    chk("clr_cnt_unc", cnt_unc, 0);

    // saturation: 32767 reads with both words corrected -> 0xFFFE
    sram_err_cor = 2'b11; req_valid = 1'b1; req_we = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    req_valid = 1'b0;
    settle();
    chk("sat_pre", cnt_cor, 16'hFFFE);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    settle();
    chk("sat_max", cnt_cor, 16'hFFFF);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    settle();
    chk("sat_hold", cnt_cor, 16'hFFFF);
    sram_err_cor = 2'b00;

    // reset during MERGE
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd2; req_wbe = 16'h0010;
    tick();
    req_valid = 1'b0; rst_n = 1'b0;
    settle();
    chk("mrst_no_write", {sram_cs, sram_we, rmw_abort}, 0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("mrst_idle", {req_ready, sram_cs, rsp_valid}, 3'b100);
    chk("mrst_cnt", cnt_cor, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
